// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: fill level, almost flags, sticky errors, sync flush; FWFT or 1-cycle registered read.
// Backpressure: writes rejected only when full without a same-cycle read; reads rejected when empty (no bypass).
module fifo_sync_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  flush,
  input  logic                  write,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  read,
  output logic [WIDTH-1:0]      data_out,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  rd_acc;
  logic                  wr_acc;

  assign wr_addr = wr_cnt[DEPTH_LOG2-1:0];
  assign rd_addr = rd_cnt[DEPTH_LOG2-1:0];

  // Counts are one bit wider than the address, so the difference is the level directly.
  assign level        = wr_cnt - rd_cnt;
  assign full         = (level == DEPTH_C);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_C);
  assign almost_empty = (level <= AE_C);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_ok  = read & ~empty;
  assign wr_ok  = write & (~full | rd_ok);
  assign rd_acc = rd_ok & ~flush;
  assign wr_acc = wr_ok & ~flush;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_cnt <= wr_cnt + 1'b1;
      if (rd_acc) rd_cnt <= rd_cnt + 1'b1;
      if (write & ~wr_ok) overflow  <= 1'b1;
      if (read & ~rd_ok)  underflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_addr];
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (flush) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (rd_acc) begin
        dout_q <= mem[rd_addr];
        vld_q  <= 1'b1;
      end else begin
        vld_q  <= 1'b0;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = vld_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: FWFT instance driven through a reference model, plus a registered-read instance.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       clrn;
  logic       flush, write, read;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] level;

  logic       r_flush, r_write, r_read;
  logic [7:0] r_data_in, r_data_out;
  logic       r_rd_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic [3:0] r_level;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         m_level;
  logic       m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH_LOG2(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_dut (
    .clk(clk), .clrn(clrn), .flush(flush), .write(write), .data_in(data_in), .read(read),
    .data_out(data_out), .rd_valid(rd_valid), .level(level), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH_LOG2(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_dut_r (
    .clk(clk), .clrn(clrn), .flush(r_flush), .write(r_write), .data_in(r_data_in), .read(r_read),
    .data_out(r_data_out), .rd_valid(r_rd_valid), .level(r_level), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .overflow(r_ovf), .underflow(r_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".level"},  32'(level),        32'(m_level));
    chk({tag, ".full"},   32'(full),         32'(m_level == 8));
    chk({tag, ".empty"},  32'(empty),        32'(m_level == 0));
    chk({tag, ".af"},     32'(almost_full),  32'(m_level >= 6));
    chk({tag, ".ae"},     32'(almost_empty), 32'(m_level <= 1));
    chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
    chk({tag, ".rdv"},    32'(rd_valid),     32'(m_level != 0));
    chk({tag, ".head"},   32'(data_out),     (m_level == 0) ? 32'h0 : 32'(exp_q[0]));
  endtask

  // One clock of stimulus on the FWFT instance; inputs change #1 after the edge.
  task automatic cyc(input string tag, input logic f, input logic w, input logic [7:0] d, input logic r);
    logic rd_ok, wr_ok;
    logic [7:0] e;
    flush = f; write = w; data_in = d; read = r;
    #1;
    rd_ok = r && (m_level > 0);
    wr_ok = w && ((m_level < 8) || rd_ok);
    if (f) begin
      exp_q.delete();
      m_level = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd_ok) begin
        e = exp_q.pop_front();
        chk({tag, ".rd_data"}, 32'(data_out), 32'(e));
        m_level--;
      end
      if (wr_ok) begin
        exp_q.push_back(d);
        m_level++;
      end
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    flush = 1'b0; write = 1'b0; read = 1'b0;
    chk_status(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    int iter;
    logic w, r;
    logic [7:0] nxt;

    clrn = 1'b0;
    flush = 0; write = 0; read = 0; data_in = '0;
    r_flush = 0; r_write = 0; r_read = 0; r_data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset");
    chk("reset.r_dout", 32'(r_data_out), 32'h0);
    chk("reset.r_rdv",  32'(r_rd_valid), 32'h0);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // Fill, watching level steps and flag thresholds.
    for (int i = 0; i < 8; i++) cyc("fill", 0, 1, 8'h11 + 8'(i), 0);

    // Overflow on a lone write to a full FIFO, then drain.
    cyc("ovf_wr", 0, 1, 8'h99, 0);
    for (int i = 0; i < 8; i++) cyc("drain1", 0, 0, 8'h00, 1);

    // Simultaneous read+write while full, starting from clean error flags.
    cyc("flush1", 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cyc("refill", 0, 1, 8'h11 + 8'(i), 0);
    cyc("full_rw", 0, 1, 8'hA0, 1);
    for (int i = 0; i < 8; i++) cyc("drain2", 0, 0, 8'h00, 1);

    // Read+write on empty: write lands, read rejected.
    cyc("empty_rw", 0, 1, 8'h55, 1);
    chk("empty_rw.dout", 32'(data_out), 32'h55);
    cyc("empty_rd", 0, 0, 8'h00, 1);

    // Interleaved stream of 20 words across pointer wrap.
    pushed = 0;
    iter = 0;
    nxt = 8'h60;
    while ((pushed < 20 || m_level > 0) && iter < 300) begin
      w = (pushed < 20) && ($urandom_range(0, 3) != 0);
      r = (pushed >= 20) || ($urandom_range(0, 1) == 1);
      if (w && (m_level < 8 || (r && m_level > 0))) begin
        cyc("stream", 0, 1, nxt, r);
        nxt++;
        pushed++;
      end else begin
        cyc("stream", 0, 0, 8'h00, r);
      end
      chk("stream.lvl_le8", 32'(level <= 4'd8), 32'h1);
      iter++;
    end
    chk("stream.done", 32'(pushed), 32'd20);

    // Flush with a concurrent write at level 5 with overflow pending.
    for (int i = 0; i < 8; i++) cyc("fill3", 0, 1, 8'hC0 + 8'(i), 0);
    cyc("ovf3", 0, 1, 8'hEE, 0);
    for (int i = 0; i < 3; i++) cyc("rd3", 0, 0, 8'h00, 1);
    chk("pre_flush.level", 32'(level), 32'd5);
    cyc("flush_wr", 1, 1, 8'h77, 0);
    chk("flush_wr.level", 32'(level), 32'd0);
    chk("flush_wr.ovf",   32'(overflow), 32'd0);

    // Registered-read instance: one-cycle latency, one-cycle valid pulse.
    r_write = 1'b1; r_data_in = 8'h3C;
    @(posedge clk);
    #1;
    r_write = 1'b0;
    chk("reg.pre_rdv", 32'(r_rd_valid), 32'h0);
    r_read = 1'b1;
    @(posedge clk);
    #1;
    r_read = 1'b0;
    chk("reg.dout",  32'(r_data_out), 32'h3C);
    chk("reg.rdv",   32'(r_rd_valid), 32'h1);
    @(posedge clk);
    #1;
    chk("reg.rdv_drop", 32'(r_rd_valid), 32'h0);
    chk("reg.hold",     32'(r_data_out), 32'h3C);
    r_flush = 1'b1;
    @(posedge clk);
    #1;
    r_flush = 1'b0;
    chk("reg.flush_dout", 32'(r_data_out), 32'h0);

    // Asynchronous reset mid-stream at level 4, checked before the next edge.
    for (int i = 0; i < 4; i++) cyc("pre_rst", 0, 1, 8'h40 + 8'(i), 0);
    cyc("pre_rst_ovf", 0, 1, 8'h00, 1);
    cyc("pre_rst_rd",  0, 0, 8'h00, 1);
    cyc("pre_rst_wr",  0, 1, 8'h44, 0);
    chk("pre_rst.level", 32'(level), 32'd4);
    #1;
    clrn = 1'b0;
    model_reset();
    #1;
    chk_status("async_rst");
    chk("async_rst.r_level", 32'(r_level), 32'h0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    @(posedge clk);
    #1;
    chk_status("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
